// File: rtl/core_pipe_exec_mdu_param.sv
// rtl/core_pipe_exec_mdu_param.sv - iterative RV M-extension multiply/divide unit for the execute stage
// Optional build macro: CORE_MDU_DIV_FAST_EN (divide-by-zero and signed overflow finish without iterating)
module core_pipe_exec_mdu_param #(
  parameter int XLEN       = 64,
  parameter int MUL_UNROLL = 4,
  parameter int DIV_UNROLL = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            valid,
  input  logic            op_word,
  input  logic [7:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            ready,
  output logic            busy,
  output logic [XLEN-1:0] rd
);

`ifdef CORE_MDU_DIV_FAST_EN
  localparam bit FAST_DIV = 1'b1;
`else
  localparam bit FAST_DIV = 1'b0;
`endif

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] MUL_X_LAST = CW'(XLEN / MUL_UNROLL - 1);
  localparam logic [CW-1:0] MUL_W_LAST = CW'(32 / MUL_UNROLL - 1);
  localparam logic [CW-1:0] DIV_X_LAST = CW'(XLEN / DIV_UNROLL - 1);
  localparam logic [CW-1:0] DIV_W_LAST = CW'(32 / DIV_UNROLL - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   ready_q;

  // latched operation context
  logic [7:0]      op_q;
  logic            word_q, sb_q, q_neg_q, a_neg_q, div0_q, ovf_q;
  logic [XLEN-1:0] a_q;
  logic [CW-1:0]   cnt_q, cnt_last;
  logic            last_step;

  // iteration datapath
  logic [2*XLEN-1:0] acc_q, acc_n, mcand_q;
  logic [XLEN-1:0]   mplier_q, rem_q, rem_n, quo_q, quo_n, dvs_q;
  logic [XLEN-1:0]   rd_q, quo_fix, rem_fix, res_raw, result;

  // accept-edge decode of the incoming request
  logic            word_in, sa_in, sb_in, a_neg_in, b_neg_in, div0_in, ovf_in;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_in;

  // Sign- or zero-extend bit 31 across the upper bits
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic s);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = (i < 32) ? v[i] : (s & v[31]);
    return r;
  endfunction

  // Operand extension, magnitudes and corner-case detection for the request
  always_comb begin
    word_in  = (XLEN == 64) && op_word;
    sa_in    = op[0] | op[1] | op[3] | op[4] | op[6];
    sb_in    = op[0] | op[1] | op[4] | op[6];
    a_ext    = word_in ? ext32(rs1, sa_in) : rs1;
    b_ext    = word_in ? ext32(rs2, sb_in) : rs2;
    a_neg_in = sa_in & a_ext[XLEN-1];
    b_neg_in = sb_in & b_ext[XLEN-1];
    a_mag    = a_neg_in ? -a_ext : a_ext;
    b_mag    = b_neg_in ? -b_ext : b_ext;
    min_in   = '0;
    for (int i = 0; i < XLEN; i++) min_in[i] = word_in ? (i >= 31) : (i == XLEN - 1);
    div0_in  = (b_ext == '0);
    ovf_in   = sa_in && (a_ext == min_in) && (b_ext == '1);
  end

  // Iteration bound for the active phase
  always_comb begin
    if (state_q == S_MUL) cnt_last = word_q ? MUL_W_LAST : MUL_X_LAST;
    else                  cnt_last = word_q ? DIV_W_LAST : DIV_X_LAST;
    last_step = (cnt_q == cnt_last);
  end

  // Shift-add multiply step; a signed multiplier subtracts its top partial product
  always_comb begin
    acc_n = acc_q;
    for (int j = 0; j < MUL_UNROLL; j++) begin
      if (mplier_q[j]) begin
        if (sb_q && last_step && (j == MUL_UNROLL - 1)) acc_n = acc_n - (mcand_q << j);
        else                                            acc_n = acc_n + (mcand_q << j);
      end
    end
  end

  // Restoring divide step on magnitudes
  always_comb begin
    logic [XLEN:0]   r;
    logic [XLEN-1:0] q;
    r = {1'b0, rem_q};
    q = quo_q;
    for (int j = 0; j < DIV_UNROLL; j++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, dvs_q}) begin
        r    = r - {1'b0, dvs_q};
        q[0] = 1'b1;
      end
    end
    rem_n = r[XLEN-1:0];
    quo_n = q;
  end

  // Final sign fix, corner cases and result select
  always_comb begin
    quo_fix = div0_q ? '1 : (ovf_q ? a_q : (q_neg_q ? -quo_q : quo_q));
    rem_fix = div0_q ? a_q : (ovf_q ? '0 : (a_neg_q ? -rem_q : rem_q));
    res_raw = '0;
    if (op_q[0])             res_raw = acc_q[XLEN-1:0];
    else if (|op_q[3:1])     res_raw = acc_q[2*XLEN-1:XLEN];
    else if (|op_q[5:4])     res_raw = quo_fix;
    else if (|op_q[7:6])     res_raw = rem_fix;
    result = word_q ? ext32(res_raw, 1'b1) : res_raw;
  end

  // Next-state logic; flush wins over everything including an accept
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && valid && (op != 8'h00)) begin
          accept = 1'b1;
          if (|op[3:0])                            state_d = S_MUL;
          else if (FAST_DIV && (div0_in || ovf_in)) state_d = S_DONE;
          else                                     state_d = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (flush)          state_d = S_IDLE;
        else if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        if (flush)                  state_d = S_IDLE;
        else if (ready_q && !valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; ready rises on the second DONE cycle once rd is captured
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_q == S_DONE) && (state_d == S_DONE);
    end
  end

  // Operand latch, iteration registers and result capture
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      op_q     <= '0;
      word_q   <= 1'b0;
      sb_q     <= 1'b0;
      q_neg_q  <= 1'b0;
      a_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rd_q     <= '0;
    end else begin
      if (accept) begin
        op_q     <= op;
        word_q   <= word_in;
        sb_q     <= sb_in;
        q_neg_q  <= sa_in & (a_neg_in ^ b_neg_in);
        a_neg_q  <= a_neg_in;
        div0_q   <= (|op[7:4]) & div0_in;
        ovf_q    <= (|op[7:4]) & ovf_in;
        a_q      <= a_ext;
        cnt_q    <= '0;
        acc_q    <= '0;
        mcand_q  <= {{XLEN{sa_in & a_ext[XLEN-1]}}, a_ext};
        mplier_q <= b_ext;
        rem_q    <= '0;
        quo_q    <= word_in ? (a_mag << 32) : a_mag;
        dvs_q    <= b_mag;
      end else if (state_q == S_MUL) begin
        acc_q    <= acc_n;
        mcand_q  <= mcand_q << MUL_UNROLL;
        mplier_q <= mplier_q >> MUL_UNROLL;
        cnt_q    <= cnt_q + 1'b1;
      end else if (state_q == S_DIV) begin
        rem_q    <= rem_n;
        quo_q    <= quo_n;
        cnt_q    <= cnt_q + 1'b1;
      end
      if ((state_q == S_DONE) && !ready_q) rd_q <= result;
    end
  end

  assign ready = ready_q & ~flush;
  assign busy  = (state_q != S_IDLE);
  assign rd    = rd_q;

endmodule
